fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly downstream of the program-counter register. Each cycle it decides whether to advance the PC, reads the synchronous instruction memory (IMEM, 1-cycle read latency) at the current PC, and hands {instruction, pc} to decode through a valid/ready interface. A small skid FIFO absorbs decode stalls. A redirect input flushes all buffered and in-flight fetches.

Parameters:
PC_WIDTH, 32, width of PC values.
IMEM_AWIDTH, 14, IMEM word-address width.
DEPTH, 2, skid FIFO entries (power of 2, >=2).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset; state clears on a rising edge while rst==0.
pc_in  input  PC_WIDTH  current PC from the PC register.
pc_en_out  output  1  enable to the PC register; PC advances or loads the redirect target at the next edge.
flush_in  input  1  redirect from execute; PC select is driven elsewhere in the same cycle.
imem_en  output  1  IMEM read enable.
imem_addr  output  IMEM_AWIDTH  word address, equal to pc_in[IMEM_AWIDTH+1:2].
imem_dout  input  32  IMEM read data, valid the cycle after imem_en.
inst_valid_out  output  1  instruction available to decode.
inst_out  output  32  instruction.
inst_pc_out  output  PC_WIDTH  PC of inst_out.
inst_ready_in  input  1  decode accepts; transfer occurs when valid && ready.

Behaviour:
- State: FIFO (data, pc, count 0..DEPTH); inflight flag plus inflight_pc register; kill flag.
- While rst==0: count=0, inflight=0, kill=0. pc_en_out, imem_en and inst_valid_out are all forced to 0.
- Issue: issue = rst && !flush_in && (count + inflight < DEPTH).
  - imem_en = issue; pc_en_out = issue || (rst && flush_in).
  - On issue: inflight<=1 and inflight_pc<=pc_in. Otherwise inflight<=0.
- Response: resp = inflight && !kill. It appears on imem_dout in the cycle after the issue.
- Output mux:
  - count>0: present the FIFO head.
  - count==0 && resp: bypass, with inst_out=imem_dout and inst_pc_out=inflight_pc.
  - Otherwise inst_valid_out=0.
- Enqueue: a resp not consumed by bypass in the same cycle is written to the FIFO tail.
- Simultaneous enqueue and dequeue: count unchanged.
- Ordering is strictly FIFO by PC issue order.
- Latency: PC seen at cycle t reaches decode at t+1 when the FIFO is empty. Throughput is 1/cycle with ready held high.
- Full: the issue condition guarantees no overflow, so no enqueue is ever dropped. Empty with no resp: valid=0, no dequeue.
- Flush (rst==1, flush_in==1):
  - No IMEM issue.
  - count<=0.
  - kill<=inflight, so a fetch issued in the flush cycle's predecessor is discarded next cycle.
  - inst_valid_out forced 0 in the flush cycle.
  - pc_en_out=1 so the PC loads the target. Issue from the new PC starts the following cycle.
  - kill clears after one cycle.
- Flush while full or while stalled: same rules; all entries are lost.
- Reset mid-stream: discards everything. The first issue is the first cycle with rst==1 (PC then holds its reset value).
- Stalls (ready=0): valid and data stay stable until accepted.

Decomposition:
- Shared header fetch_defs.vh holds INST_WIDTH=32 and INST_NOP=32'h00000013 (for downstream bubbles).
- Natural sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO with count output and clear input, storing {pc, inst}.
- Issue/kill/bypass logic stays in fetch_unit.

Test Plan:
1. Reset then run, with IMEM[k]=0x1000+k, PC reset 0, ready=1 → decode receives (0x1000, 0x0), (0x1001, 0x4), (0x1002, 0x8), … one per cycle, the first in the 2nd cycle after rst rises.
2. Stall: drop ready for 4 cycles mid-stream at PC 0x8 → at most 2 further PCs are fetched and pc_en_out=0 once full. Resuming gives the sequence with no gap, duplicate or loss (0x8, 0xC, 0x10…).
3. Flush while stalled with FIFO full, target 0x40 → inst_valid_out=0 during the flush cycle. The next delivered instruction is (IMEM[0x10], 0x40), and no pre-flush instruction appears.
4. Flush with ready=1 mid-stream → the in-flight fetch is killed, and the first post-flush valid is at the target two cycles after flush.
5. Reset asserted while full and in flight → all outputs are 0 while rst==0. After release the sequence restarts at the PC reset value.
6. Randomised ready/flush for 10k cycles against a scoreboard model → in-order delivery, each inst matches IMEM[pc>>2], and there is never an enqueue while count==DEPTH.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared instruction constants and types for the fetch stage
package fetch_unit_pkg;
  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h0000_0013;
  typedef logic [INST_WIDTH-1:0] inst_t;
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry synchronous skid FIFO with occupancy count and clear
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      count_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven IMEM fetch with bypass, skid FIFO and redirect flush
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter int IMEM_AWIDTH = 14,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   pc_en_out,
  input  logic                   flush_in,
  output logic                   imem_en,
  output logic [IMEM_AWIDTH-1:0] imem_addr,
  input  inst_t                  imem_dout,
  output logic                   inst_valid_out,
  output inst_t                  inst_out,
  output logic [PC_WIDTH-1:0]    inst_pc_out,
  input  logic                   inst_ready_in
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W = PC_WIDTH + INST_WIDTH;
  logic inflight_q, kill_q, resp, issue, head_ok, push, pop;
  logic [PC_WIDTH-1:0] inflight_pc_q;
  logic [CW-1:0] count;
  logic [W-1:0] head;
  always_comb begin
    head_ok = count != '0;
    resp = inflight_q && !kill_q;
    issue = rst && !flush_in && ({1'b0, count} + (CW + 1)'(inflight_q) < (CW + 1)'(DEPTH));
    inst_valid_out = rst && !flush_in && (head_ok || resp);
    pop = head_ok && inst_valid_out && inst_ready_in;
    push = resp && (head_ok || !inst_ready_in);
    imem_en = issue;
    pc_en_out = issue || (rst && flush_in);
    imem_addr = pc_in[IMEM_AWIDTH+1:2];
    inst_out = !inst_valid_out ? INST_NOP : head_ok ? head[INST_WIDTH-1:0] : imem_dout;
    inst_pc_out = !inst_valid_out ? '0 : head_ok ? head[W-1:INST_WIDTH] : inflight_pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      kill_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      kill_q <= flush_in && inflight_q;
    end
    if (issue) inflight_pc_q <= pc_in;
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_in),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({inflight_pc_q, imem_dout}),
    .rdata_o (head),
    .count_o (count)
  );
endmodule
